// File: rtl/sig_meter_pkg.sv
// Shared definitions for the signal peak meter.
// - Result-mode encodings selected on the meter's mode input.
// - Width helper for the per-channel result (one bit wider than a sample,
//   so that max-min and |-2^(N-1)| fit without overflow).
package sig_meter_pkg;

  localparam logic [1:0] MODE_P2P    = 2'd0;
  localparam logic [1:0] MODE_MAX    = 2'd1;
  localparam logic [1:0] MODE_MIN    = 2'd2;
  localparam logic [1:0] MODE_MAXABS = 2'd3;

  function automatic int ampl_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/sig_peak_ch.sv
// Per-channel tracker for the signal peak meter.
// Holds the running max/min of one signed sample stream and, on the last
// sample of a window, registers the mode-selected result.
// Optional mean accumulator is built when SIG_PEAK_METER_MEAN_EN is defined.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   take       a sample is accepted this cycle (valid and not cleared)
//   first      accepted sample is the first of its window
//   last       accepted sample is the last of its window
//   mode       mode latched for the current window
//   sample     signed sample for this channel
//   ampl       registered result, DATA_W+1 bits
//   mean       registered window mean (only with SIG_PEAK_METER_MEAN_EN)
module sig_peak_ch
  import sig_meter_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 17
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     take,
  input  logic                     first,
  input  logic                     last,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] sample,
`ifdef SIG_PEAK_METER_MEAN_EN
  output logic [DATA_W-1:0]        mean,
`endif
  output logic [DATA_W:0]          ampl
);

  localparam int RES_W = ampl_width(DATA_W);

  logic signed [DATA_W-1:0] max_q, min_q, max_n, min_n;
  logic signed [RES_W-1:0]  max_x, min_x;
  logic [RES_W-1:0]         abs_max, abs_min, res;

  // Next max/min including the current sample; the first sample of a window
  // seeds both, so no sentinel values are needed.
  always_comb begin
    max_n = max_q;
    min_n = min_q;
    if (first) begin
      max_n = sample;
      min_n = sample;
    end else begin
      max_n = (sample > max_q) ? sample : max_q;
      min_n = (sample < min_q) ? sample : min_q;
    end
  end

  // Result mux on the completed window extremes, all in DATA_W+1 bits.
  always_comb begin
    max_x   = {max_n[DATA_W-1], max_n};
    min_x   = {min_n[DATA_W-1], min_n};
    abs_max = max_x[RES_W-1] ? $unsigned(-max_x) : $unsigned(max_x);
    abs_min = min_x[RES_W-1] ? $unsigned(-min_x) : $unsigned(min_x);
    case (mode)
      MODE_P2P:    res = $unsigned(max_x - min_x);
      MODE_MAX:    res = $unsigned(max_x);
      MODE_MIN:    res = $unsigned(min_x);
      MODE_MAXABS: res = (abs_max > abs_min) ? abs_max : abs_min;
      default:     res = $unsigned(max_x - min_x);
    endcase
  end

`ifdef SIG_PEAK_METER_MEAN_EN
  localparam int ACC_W = DATA_W + WIN_LOG2;

  logic signed [ACC_W-1:0] acc_q, acc_n, smp_x;

  // Window sum; a full window of extreme samples fits exactly in ACC_W bits.
  always_comb begin
    smp_x = {{WIN_LOG2{sample[DATA_W-1]}}, sample};
    if (first) begin
      acc_n = smp_x;
    end else begin
      acc_n = acc_q + smp_x;
    end
  end

  // Accumulator and mean output; taking the upper DATA_W bits is the
  // arithmetic right shift by WIN_LOG2 (floor toward minus infinity).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= {ACC_W{1'b0}};
      mean  <= {DATA_W{1'b0}};
    end else begin
      if (take) begin
        acc_q <= acc_n;
      end
      if (take && last) begin
        mean <= acc_n[WIN_LOG2 +: DATA_W];
      end
    end
  end
`endif

  // Running extremes and the held result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_q <= {DATA_W{1'b0}};
      min_q <= {DATA_W{1'b0}};
      ampl  <= {RES_W{1'b0}};
    end else begin
      if (take) begin
        max_q <= max_n;
        min_q <= min_n;
      end
      if (take && last) begin
        ampl <= res;
      end
    end
  end

endmodule

// File: rtl/sig_peak_meter.sv
// Multi-channel signal amplitude meter.
// Tracks per-channel max/min over windows of 2^WIN_LOG2 valid samples and
// emits a mode-selected result with a one-cycle out_valid strobe.
// Optional feature macro: SIG_PEAK_METER_MEAN_EN adds per-channel out_mean.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   in_valid   sample strobe shared by all channels
//   in_data    NUM_CH signed samples, channel k at [k*DATA_W +: DATA_W]
//   mode       0 p2p, 1 max, 2 min, 3 max-abs (latched on window start)
//   clear      synchronous window restart, wins over in_valid
//   out_valid  one-cycle result strobe
//   out_ampl   per-channel result, channel k at [k*(DATA_W+1) +: DATA_W+1]
//   out_mean   per-channel window mean (only with SIG_PEAK_METER_MEAN_EN)
module sig_peak_meter
  import sig_meter_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int WIN_LOG2 = 17
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [1:0]                 mode,
  input  logic                       clear,
  output logic                       out_valid,
`ifdef SIG_PEAK_METER_MEAN_EN
  output logic [NUM_CH*DATA_W-1:0]   out_mean,
`endif
  output logic [NUM_CH*(DATA_W+1)-1:0] out_ampl
);

  localparam int RES_W = ampl_width(DATA_W);
  localparam logic [WIN_LOG2-1:0] CNT_ONE = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  logic [WIN_LOG2-1:0] cnt;
  logic [1:0]          mode_lat;
  logic                take, first, last;

  assign take  = in_valid & ~clear;
  assign first = (cnt == {WIN_LOG2{1'b0}});
  assign last  = (cnt == {WIN_LOG2{1'b1}});

  // Window counter, mode latch and result strobe. The mode is captured on a
  // window's first sample; the channel result mux reads it at the last one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= {WIN_LOG2{1'b0}};
      mode_lat  <= MODE_P2P;
      out_valid <= 1'b0;
    end else begin
      out_valid <= take & last;
      if (clear) begin
        cnt <= {WIN_LOG2{1'b0}};
      end else if (in_valid) begin
        cnt <= cnt + CNT_ONE;
        if (first) begin
          mode_lat <= mode;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sig_peak_ch #(
      .DATA_W   (DATA_W),
      .WIN_LOG2 (WIN_LOG2)
    ) u_ch (
      .clk    (clk),
      .rstn   (rstn),
      .take   (take),
      .first  (first),
      .last   (last),
      .mode   (mode_lat),
      .sample (in_data[k*DATA_W +: DATA_W]),
`ifdef SIG_PEAK_METER_MEAN_EN
      .mean   (out_mean[k*DATA_W +: DATA_W]),
`endif
      .ampl   (out_ampl[k*RES_W +: RES_W])
    );
  end

endmodule

// File: tb/tb_sig_peak_meter.sv
// Self-checking bench for sig_peak_meter (DATA_W=16, NUM_CH=2, WIN_LOG2=3).
// A window-level reference model (array of samples per window, results from
// max/min/sum arithmetic) is compared against the DUT every cycle, and the
// directed scenarios additionally pin hand-computed literal results.
module tb_sig_peak_meter;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int WL = 3;
  localparam int WN = 8;
  localparam int RW = 17;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            in_valid = 1'b0;
  logic [NC*DW-1:0] in_data = '0;
  logic [1:0]      mode = 2'd0;
  logic            clear = 1'b0;
  logic            out_valid;
  logic [NC*RW-1:0] out_ampl;
`ifdef SIG_PEAK_METER_MEAN_EN
  logic [NC*DW-1:0] out_mean;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [1:0] cur_mode = 2'd0;

  sig_peak_meter #(.DATA_W(DW), .NUM_CH(NC), .WIN_LOG2(WL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mode      (mode),
    .clear     (clear),
    .out_valid (out_valid),
`ifdef SIG_PEAK_METER_MEAN_EN
    .out_mean  (out_mean),
`endif
    .out_ampl  (out_ampl)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_cnt = 0;
  int         m_mode = 0;
  int         smp [NC][WN];
  logic       m_valid = 1'b0;
  logic [NC*RW-1:0] m_ampl = '0;
  logic [NC*DW-1:0] m_mean = '0;

  function automatic logic [RW-1:0] exp_res(input int ch, input int md);
    int mx, mn, r, amx, amn;
    logic [31:0] t;
    mx = smp[ch][0];
    mn = smp[ch][0];
    for (int i = 1; i < WN; i++) begin
      if (smp[ch][i] > mx) mx = smp[ch][i];
      if (smp[ch][i] < mn) mn = smp[ch][i];
    end
    amx = (mx < 0) ? -mx : mx;
    amn = (mn < 0) ? -mn : mn;
    case (md)
      0: r = mx - mn;
      1: r = mx;
      2: r = mn;
      default: r = (amx > amn) ? amx : amn;
    endcase
    t = r;
    return t[RW-1:0];
  endfunction

  function automatic logic [DW-1:0] exp_mean(input int ch);
    int s, r;
    logic [31:0] t;
    s = 0;
    for (int i = 0; i < WN; i++) s += smp[ch][i];
    r = (s - (((s % WN) + WN) % WN)) / WN;
    t = r;
    return t[DW-1:0];
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0;
      m_mode = 0;
      m_valid = 1'b0;
      m_ampl = '0;
      m_mean = '0;
    end else begin
      m_valid = 1'b0;
      if (clear) begin
        m_cnt = 0;
      end else if (in_valid) begin
        if (m_cnt == 0) m_mode = int'(mode);
        for (int ch = 0; ch < NC; ch++) smp[ch][m_cnt] = int'($signed(in_data[ch*DW +: DW]));
        m_cnt++;
        if (m_cnt == WN) begin
          m_cnt = 0;
          m_valid = 1'b1;
          for (int ch = 0; ch < NC; ch++) begin
            m_ampl[ch*RW +: RW] = exp_res(ch, m_mode);
            m_mean[ch*DW +: DW] = exp_mean(ch);
          end
        end
      end
    end
  end

  // Per-cycle comparison, sampled 6 time units after the active edge.
  always @(posedge clk) begin
    #6;
    if (chk_en) begin
      checks++;
      if (out_valid !== m_valid) begin
        failures++;
        $display("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, m_valid, $time);
      end
      checks++;
      if (out_ampl !== m_ampl) begin
        failures++;
        $display("FAIL out_ampl got=%h exp=%h t=%0t", out_ampl, m_ampl, $time);
      end
`ifdef SIG_PEAK_METER_MEAN_EN
      checks++;
      if (out_mean !== m_mean) begin
        failures++;
        $display("FAIL out_mean got=%h exp=%h t=%0t", out_mean, m_mean, $time);
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic v, input int a, input int b, input logic c);
    @(posedge clk);
    #2;
    in_valid = v;
    in_data  = {b[DW-1:0], a[DW-1:0]};
    mode     = cur_mode;
    clear    = c;
  endtask

  task automatic send(input int a, input int b);
    step(1'b1, a, b, 1'b0);
  endtask

  // Drops in_valid, waits (bounded) for out_valid and pins literal results.
  task automatic expect_result(input string name, input logic [RW-1:0] e0,
                               input logic [RW-1:0] e1, input logic [DW-1:0] mn0,
                               input logic [DW-1:0] mn1);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      clear = 1'b0;
      #4;
      if (out_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s no out_valid within 20 cycles", name);
    end else begin
      checks += 2;
      if (out_ampl[0 +: RW] !== e0) begin
        failures++;
        $display("FAIL %s ch0 ampl got=%h exp=%h", name, out_ampl[0 +: RW], e0);
      end
      if (out_ampl[RW +: RW] !== e1) begin
        failures++;
        $display("FAIL %s ch1 ampl got=%h exp=%h", name, out_ampl[RW +: RW], e1);
      end
`ifdef SIG_PEAK_METER_MEAN_EN
      checks += 2;
      if (out_mean[0 +: DW] !== mn0) begin
        failures++;
        $display("FAIL %s ch0 mean got=%h exp=%h", name, out_mean[0 +: DW], mn0);
      end
      if (out_mean[DW +: DW] !== mn1) begin
        failures++;
        $display("FAIL %s ch1 mean got=%h exp=%h", name, out_mean[DW +: DW], mn1);
      end
`else
      if (mn0 === mn1) begin end
`endif
    end
  endtask

  function automatic int rnd_sample();
    int r;
    logic [31:0] u;
    r = $urandom_range(0, 9);
    u = $urandom;
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($signed(u[15:0]));
  endfunction

  int s2a[8] = '{100, -200, 300, 0, 5, -5, 7, -1};
  int s3a[8] = '{5, -32768, 1000, -3, 0, 12, 999, -1000};

  initial begin
    #1 rstn = 1'b0;
    #1 chk_en = 1'b1;

    // 1: reset held with in_valid toggling, then one full window
    for (int i = 0; i < 6; i++) step(i % 2 == 0, 1000 * i, -5, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) send(10 * (i + 1), 0);
    expect_result("reset_window", 17'd70, 17'd0, 16'd45, 16'd0);

    // 2: peak-to-peak
    cur_mode = 2'd0;
    for (int i = 0; i < 8; i++) send(s2a[i], 42);
    expect_result("p2p", 17'd500, 17'd0, 16'd25, 16'd42);

    // 3: max-abs then min with -32768 in the window
    cur_mode = 2'd3;
    for (int i = 0; i < 8; i++) send(s3a[i], 1);
    expect_result("maxabs", 17'h08000, 17'h00001, 16'hf07e, 16'd1);
    cur_mode = 2'd2;
    for (int i = 0; i < 8; i++) send(s3a[i], 1);
    expect_result("min", 17'h18000, 17'h00001, 16'hf07e, 16'd1);

    // 4: sparse valids, mode change mid-window applies to next window
    cur_mode = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) cur_mode = 2'd1;
      send(rnd_sample(), rnd_sample());
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);

    // 5: clear discards a partial window and its own sample
    cur_mode = 2'd1;
    for (int i = 0; i < 5; i++) send(1000 + i, -2000);
    step(1'b1, 2000, 3000, 1'b1);
    for (int i = 0; i < 8; i++) send(7, 7);
    expect_result("clear", 17'd7, 17'd7, 16'd7, 16'd7);

    // 6: short reset pulse mid-window
    cur_mode = 2'd0;
    for (int i = 0; i < 4; i++) send(5000, -5000);
    @(posedge clk);
    #2 rstn = 1'b0;
    in_valid = 1'b0;
    #4;
    checks += 2;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_pulse out_valid got=%0b exp=0", out_valid);
    end
    if (out_ampl !== '0) begin
      failures++;
      $display("FAIL rst_pulse out_ampl got=%h exp=0", out_ampl);
    end
    @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 8; i++) send(i + 1, -(i + 1));
    expect_result("after_reset", 17'd7, 17'd7, 16'd4, 16'hfffb);

    // Random phase
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 7, rnd_sample(), rnd_sample(),
           $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #8;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sig_peak_meter.md
# sig_peak_meter

Multi-channel signal amplitude meter for the filter-study chain: tracks per-channel maximum and minimum of a signed sample stream over a window of 2^WIN_LOG2 valid samples. At each window end it emits a result selected by a run-time mode, with a one-cycle result strobe. It sits after the CIC/FIR outputs and feeds the 7-segment display or a serial readback. It is the generalised successor of the fixed single-channel, 16-bit, peak-to-peak-only measurement.

## Interface
- DATA_W, 16: signed sample width per channel.
- NUM_CH, 2: number of independent channels (1..8).
- WIN_LOG2, 17: window length is 2^WIN_LOG2 valid samples (2..24).

- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- in_valid  in  1  sample strobe, common to all channels.
- in_data  in  NUM_CH*DATA_W  signed samples; channel k at bits [k*DATA_W +: DATA_W].
- mode  in  2  0 peak-to-peak, 1 max, 2 min, 3 max-abs.
- clear  in  1  synchronous window restart.
- out_valid  out  1  one-cycle result strobe.
- out_ampl  out  NUM_CH*(DATA_W+1)  per-channel result, channel k at [k*(DATA_W+1) +: DATA_W+1].
- out_mean  out  NUM_CH*DATA_W  per-channel window mean; present only with SIG_PEAK_METER_MEAN_EN.

## Operation
- The window counter (WIN_LOG2 bits) increments only on in_valid. Cycles without in_valid do not advance the window.
- First sample of a window loads max=min=sample; no sentinels. Later samples update max/min by signed compare.
- The last sample, with count = 2^WIN_LOG2-1, is included in the result. The counter then wraps to 0 and the next sample starts a new window.
- mode is latched on the first sample of each window. A mode change mid-window applies to the next window.
- Results are computed on the completed max/min:
  - mode 0: max-min, unsigned, DATA_W+1 bits, never overflows.
  - mode 1: max, sign-extended to DATA_W+1.
  - mode 2: min, sign-extended to DATA_W+1.
  - mode 3: max(|max|,|min|), unsigned DATA_W+1. -2^(DATA_W-1) yields 2^(DATA_W-1).
- out_ampl/out_mean hold their value until the next window completes.
- clear takes priority over in_valid. The partial window is discarded, the counter goes to 0, the sample in the clear cycle is discarded, no out_valid is produced, and outputs keep their last value.

## Timing
- Reset (rstn low): out_valid=0, out_ampl=0, out_mean=0, counter=0, max/min=0, latched mode=0. Takes effect immediately and asynchronously.
- Latency: out_valid and new out_ampl appear the cycle after the clk edge that samples the last in_valid of a window.
- in_valid on consecutive cycles across a window boundary is fully supported; no sample is dropped and there are no bubbles.
- Reset deasserted mid-stream: the first in_valid after release is sample 0 of a window.

## Configuration
- SIG_PEAK_METER_MEAN_EN defined:
  - adds a per-channel signed accumulator of DATA_W+WIN_LOG2 bits.
  - first sample of a window loads the accumulator.
  - out_mean = accumulator arithmetic-shifted right by WIN_LOG2, truncated toward minus infinity.
  - out_mean updates with out_valid; clear discards the accumulator.
- Not defined: no accumulator logic and no out_mean port.

## Structure
- Shared package sig_meter_pkg:
  - mode encoding constants MODE_P2P=0, MODE_MAX=1, MODE_MIN=2, MODE_MAXABS=3.
  - width helper for the result width DATA_W+1.
- Sub-module sig_peak_ch holds the per-channel max/min/accumulator tracker and result mux. It is instantiated NUM_CH times by generate. The top holds the window counter, mode latch, clear logic and out_valid.

## Test plan
All scenarios use DATA_W=16, NUM_CH=2, WIN_LOG2=3.
1. Reset: hold rstn=0 with in_valid toggling -> out_valid=0, out_ampl=0 throughout. Release rstn, then 8 valids -> exactly one out_valid, one cycle after the 8th.
2. Mode 0, channel 0 = 100,-200,300,0,5,-5,7,-1 and channel 1 constant 42 -> ch0 out_ampl=500, ch1 out_ampl=0. With MEAN_EN: ch0 out_mean=25, ch1 out_mean=42.
3. Mode 3, channel 0 including -32768, others ≤ 1000 -> out_ampl=32768 (17'h08000). Mode 2 on the same data -> 17'h18000.
4. in_valid asserted every third cycle for 16 samples, and mode switched 0→1 after sample 4 -> two out_valid pulses. Window 1 reports peak-to-peak, window 2 reports max.
5. Five samples, then clear concurrent with a valid sample, then 8 samples of value 7 in mode 1 -> single out_valid after those 8, out_ampl=7. The pre-clear samples do not contribute.
6. rstn pulsed low for one cycle after 4 samples -> outputs return to 0 immediately. The next 8 valids form a complete window.
